carpma_bolme_birimi: RTL and testbench

Parametrised multi-cycle multiply/divide unit (RISC-V M extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that sits beside the single-cycle ALU in the execute stage. It takes the M-extension operations off the single-cycle path and runs them with a radix-2 iterative datapath of width XLEN. It uses a valid/ready request handshake, a stall-held result and a flush input. It also implements the architectural divide-by-zero and signed-overflow results.

---
 rtl/carpma_bolme_birimi.sv | 230 +++++++++++++++++++++++
 tb/tb_carpma_bolme_birimi.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/carpma_bolme_birimi.sv
`default_nettype none
// ============================================================================
//  Module   : carpma_bolme_birimi
//  Brief    : Radix-2 iterative multiply/divide unit for the RV M extension
//             (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). Define
//             CARPMA_BOLME_HIZLI_CARPMA_EN for single-cycle multiplies.
//  Revision : 1.0 - initial release
// ============================================================================
module carpma_bolme_birimi #(
    parameter int XLEN    = 32,
    parameter int SAYAC_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            istek_gecerli_i,
    input  logic [2:0]      islem_i,
    input  logic [XLEN-1:0] deger1_i,
    input  logic [XLEN-1:0] deger2_i,
    input  logic            durdur_i,
    input  logic            iptal_i,
    output logic            hazir_o,
    output logic            sonuc_gecerli_o,
    output logic [XLEN-1:0] sonuc_o
);

    localparam logic [1:0] c_BOSTA   = 2'd0;
    localparam logic [1:0] c_HESAPLA = 2'd1;
    localparam logic [1:0] c_SONUC   = 2'd2;

    localparam logic [2:0] c_MUL    = 3'd0;
    localparam logic [2:0] c_MULH   = 3'd1;
    localparam logic [2:0] c_MULHSU = 3'd2;
    localparam logic [2:0] c_MULHU  = 3'd3;
    localparam logic [2:0] c_DIV    = 3'd4;
    localparam logic [2:0] c_DIVU   = 3'd5;
    localparam logic [2:0] c_REM    = 3'd6;
    localparam logic [2:0] c_REMU   = 3'd7;

    localparam logic [XLEN-1:0] c_EN_KUCUK = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]         r_durum;
    logic [SAYAC_W-1:0] r_sayac;
    logic [2:0]         r_islem;
    logic               r_sonuc_neg;
    logic               r_kalan_neg;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_ust;
    logic [XLEN-1:0]    r_alt;
    logic [XLEN-1:0]    r_sonuc;

    // ---------------- accept-time decode ----------------
    logic            w_kabul;
    logic            w_bolme;
    logic            w_isaretli1;
    logic            w_isaretli2;
    logic            w_isaret1;
    logic            w_isaret2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_sifir;
    logic            w_tasma;
    logic            w_ozel;
    logic [XLEN-1:0] w_ozel_sonuc;
    logic            w_hizli;
    logic [XLEN-1:0] w_hizli_sonuc;

    assign w_kabul = (r_durum == c_BOSTA) && istek_gecerli_i && !iptal_i;
    assign w_bolme = islem_i[2];

    always_comb begin
        w_isaretli1 = 1'b0;
        w_isaretli2 = 1'b0;
        case (islem_i)
            c_MULH, c_DIV, c_REM: begin
                w_isaretli1 = 1'b1;
                w_isaretli2 = 1'b1;
            end
            c_MULHSU: w_isaretli1 = 1'b1;
            default: ;
        endcase
    end

    assign w_isaret1 = w_isaretli1 & deger1_i[XLEN-1];
    assign w_isaret2 = w_isaretli2 & deger2_i[XLEN-1];
    assign w_mag1    = w_isaret1 ? (~deger1_i + 1'b1) : deger1_i;
    assign w_mag2    = w_isaret2 ? (~deger2_i + 1'b1) : deger2_i;

    // Signed overflow only exists for DIV/REM (funct3 bit 0 clear).
    assign w_sifir = (deger2_i == '0);
    assign w_tasma = !islem_i[0] && (deger1_i == c_EN_KUCUK) && (deger2_i == '1);
    assign w_ozel  = w_bolme && (w_sifir || w_tasma);

    always_comb begin
        w_ozel_sonuc = '0;
        if (w_sifir)
            w_ozel_sonuc = islem_i[1] ? deger1_i : '1;
        else
            w_ozel_sonuc = islem_i[1] ? '0 : deger1_i;
    end

`ifdef CARPMA_BOLME_HIZLI_CARPMA_EN
    logic signed [XLEN:0]     w_h_op1;
    logic signed [XLEN:0]     w_h_op2;
    logic signed [2*XLEN+1:0] w_h_urun;

    assign w_h_op1  = $signed({w_isaretli1 & deger1_i[XLEN-1], deger1_i});
    assign w_h_op2  = $signed({w_isaretli2 & deger2_i[XLEN-1], deger2_i});
    assign w_h_urun = w_h_op1 * w_h_op2;
    assign w_hizli  = !w_bolme;
    assign w_hizli_sonuc = (islem_i == c_MUL) ? w_h_urun[XLEN-1:0]
                                              : w_h_urun[2*XLEN-1:XLEN];
`else
    assign w_hizli       = 1'b0;
    assign w_hizli_sonuc = '0;
`endif

    // ---------------- iteration datapath ----------------
    // Shared registers: multiply keeps {r_ust, r_alt} as the 2*XLEN accumulator
    // with the multiplier in r_alt; divide keeps remainder in r_ust and
    // dividend/quotient in r_alt. r_b holds multiplicand or divisor magnitude.
    logic [XLEN:0]   w_topla;
    logic [XLEN-1:0] w_carp_ust;
    logic [XLEN-1:0] w_carp_alt;
    logic [XLEN:0]   w_deneme;
    logic [XLEN:0]   w_fark;
    logic            w_sigar;
    logic [XLEN-1:0] w_bol_ust;
    logic [XLEN-1:0] w_bol_alt;
    logic [XLEN-1:0] w_ust_yeni;
    logic [XLEN-1:0] w_alt_yeni;

    assign w_topla    = {1'b0, r_ust} + (r_alt[0] ? {1'b0, r_b} : '0);
    assign w_carp_ust = w_topla[XLEN:1];
    assign w_carp_alt = {w_topla[0], r_alt[XLEN-1:1]};

    // Remainder stays below the divisor, so bit XLEN of the difference is a
    // reliable borrow flag.
    assign w_deneme  = {r_ust, r_alt[XLEN-1]};
    assign w_fark    = w_deneme - {1'b0, r_b};
    assign w_sigar   = !w_fark[XLEN];
    assign w_bol_ust = w_sigar ? w_fark[XLEN-1:0] : w_deneme[XLEN-1:0];
    assign w_bol_alt = {r_alt[XLEN-2:0], w_sigar};

    assign w_ust_yeni = r_islem[2] ? w_bol_ust : w_carp_ust;
    assign w_alt_yeni = r_islem[2] ? w_bol_alt : w_carp_alt;

    // ---------------- final sign correction ----------------
    logic [2*XLEN-1:0] w_urun;
    logic [2*XLEN-1:0] w_urun_s;
    logic [XLEN-1:0]   w_bolum_s;
    logic [XLEN-1:0]   w_kalan_s;
    logic [XLEN-1:0]   w_son_sonuc;

    assign w_urun    = {w_ust_yeni, w_alt_yeni};
    assign w_urun_s  = r_sonuc_neg ? (~w_urun + 1'b1) : w_urun;
    assign w_bolum_s = r_sonuc_neg ? (~w_alt_yeni + 1'b1) : w_alt_yeni;
    assign w_kalan_s = r_kalan_neg ? (~w_ust_yeni + 1'b1) : w_ust_yeni;

    always_comb begin
        w_son_sonuc = '0;
        case (r_islem)
            c_MUL:                    w_son_sonuc = w_urun_s[XLEN-1:0];
            c_MULH, c_MULHSU, c_MULHU: w_son_sonuc = w_urun_s[2*XLEN-1:XLEN];
            c_DIV, c_DIVU:            w_son_sonuc = w_bolum_s;
            c_REM, c_REMU:            w_son_sonuc = w_kalan_s;
            default:                  w_son_sonuc = '0;
        endcase
    end

    // ---------------- control ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_durum     <= c_BOSTA;
            r_sayac     <= '0;
            r_islem     <= c_MUL;
            r_sonuc_neg <= 1'b0;
            r_kalan_neg <= 1'b0;
            r_b         <= '0;
            r_ust       <= '0;
            r_alt       <= '0;
            r_sonuc     <= '0;
        end else if (iptal_i) begin
            r_durum <= c_BOSTA;
            r_sayac <= '0;
        end else begin
            case (r_durum)
                c_BOSTA: begin
                    if (w_kabul) begin
                        r_islem     <= islem_i;
                        r_sonuc_neg <= w_isaret1 ^ w_isaret2;
                        r_kalan_neg <= w_isaret1;
                        r_b         <= w_bolme ? w_mag2 : w_mag1;
                        r_alt       <= w_bolme ? w_mag1 : w_mag2;
                        r_ust       <= '0;
                        if (w_ozel) begin
                            r_sonuc <= w_ozel_sonuc;
                            r_durum <= c_SONUC;
                        end else if (w_hizli) begin
                            r_sonuc <= w_hizli_sonuc;
                            r_durum <= c_SONUC;
                        end else begin
                            r_sayac <= SAYAC_W'(XLEN);
                            r_durum <= c_HESAPLA;
                        end
                    end
                end
                c_HESAPLA: begin
                    r_ust   <= w_ust_yeni;
                    r_alt   <= w_alt_yeni;
                    r_sayac <= r_sayac - SAYAC_W'(1);
                    if (r_sayac == SAYAC_W'(1)) begin
                        r_sonuc <= w_son_sonuc;
                        r_durum <= c_SONUC;
                    end
                end
                c_SONUC: begin
                    if (!durdur_i)
                        r_durum <= c_BOSTA;
                end
                default: r_durum <= c_BOSTA;
            endcase
        end
    end

    assign hazir_o         = (r_durum == c_BOSTA);
    assign sonuc_gecerli_o = (r_durum == c_SONUC);
    assign sonuc_o         = r_sonuc;

endmodule
`default_nettype wire

// File: tb/tb_carpma_bolme_birimi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_carpma_bolme_birimi
//  Brief    : Directed self-checking bench for carpma_bolme_birimi (XLEN=32)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_carpma_bolme_birimi;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        istek_gecerli_i = 1'b0;
    logic [2:0]  islem_i = 3'd0;
    logic [31:0] deger1_i = '0;
    logic [31:0] deger2_i = '0;
    logic        durdur_i = 1'b0;
    logic        iptal_i = 1'b0;
    logic        hazir_o;
    logic        sonuc_gecerli_o;
    logic [31:0] sonuc_o;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef CARPMA_BOLME_HIZLI_CARPMA_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    carpma_bolme_birimi #(.XLEN(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .istek_gecerli_i (istek_gecerli_i),
        .islem_i         (islem_i),
        .deger1_i        (deger1_i),
        .deger2_i        (deger2_i),
        .durdur_i        (durdur_i),
        .iptal_i         (iptal_i),
        .hazir_o         (hazir_o),
        .sonuc_gecerli_o (sonuc_gecerli_o),
        .sonuc_o         (sonuc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for the result, check latency/value/exit.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int  lat;
        bit  got;
        @(negedge clk_i);
        islem_i = op; deger1_i = a; deger2_i = b; istek_gecerli_i = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk_i); #1;
            istek_gecerli_i = 1'b0;
            lat++;
            if (sonuc_gecerli_o) got = 1'b1;
        end
        chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
        chk(tag, sonuc_o, exp);
        chk({tag, " hazir_in_sonuc"}, {31'b0, hazir_o}, 32'd0);
        @(posedge clk_i); #1;
        chk({tag, " hazir_after"}, {31'b0, hazir_o}, 32'd1);
    endtask

    initial begin
        bit seen;
        // ---- reset ----
        #1 rst_i = 1'b0;
        #2;
        chk("rst hazir", {31'b0, hazir_o}, 32'd1);
        chk("rst gecerli", {31'b0, sonuc_gecerli_o}, 32'd0);
        chk("rst sonuc", sonuc_o, 32'h0);
        @(negedge clk_i); rst_i = 1'b1;

        // ---- division ----
        do_op("DIV 7/-2",   3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        do_op("REM 7/-2",   3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33);
        do_op("DIV -7/2",   3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
        do_op("REM -7/2",   3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
        do_op("DIVU x/0",   3'd5, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1);
        do_op("REMU x/0",   3'd7, 32'h12345678, 32'h00000000, 32'h12345678, 1);
        do_op("DIV ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("REM ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // ---- multiplication ----
        do_op("MULH min2",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        do_op("MULHSU",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
        do_op("MULHU",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        do_op("MUL -1*-1",  3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT);
        do_op("MUL 3*-5",   3'd0, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF1, MUL_LAT);
        do_op("MULH -1*1",  3'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, MUL_LAT);

        // ---- stall held in SONUC for 5 cycles ----
        @(negedge clk_i);
        durdur_i = 1'b1;
        islem_i = 3'd5; deger1_i = 32'd100; deger2_i = 32'd7; istek_gecerli_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk_i); #1;
            istek_gecerli_i = 1'b0;
            if (sonuc_gecerli_o) seen = 1'b1;
        end
        chk("stall reached", {31'b0, seen}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            @(posedge clk_i); #1;
            chk("stall gecerli", {31'b0, sonuc_gecerli_o}, 32'd1);
            chk("stall sonuc", sonuc_o, 32'd14);
        end
        @(negedge clk_i); durdur_i = 1'b0;
        @(posedge clk_i); #1;
        chk("stall exit hazir", {31'b0, hazir_o}, 32'd1);
        chk("stall exit gecerli", {31'b0, sonuc_gecerli_o}, 32'd0);
        chk("stall hold sonuc", sonuc_o, 32'd14);

        // ---- flush 10 cycles into a DIV ----
        @(negedge clk_i);
        islem_i = 3'd4; deger1_i = 32'd1000; deger2_i = 32'd3; istek_gecerli_i = 1'b1;
        @(posedge clk_i); #1; istek_gecerli_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i); iptal_i = 1'b1;
        @(posedge clk_i); #1; iptal_i = 1'b0;
        chk("flush hazir", {31'b0, hazir_o}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (sonuc_gecerli_o) seen = 1'b1;
        end
        chk("flush no gecerli", {31'b0, seen}, 32'd0);
        chk("flush sonuc kept", sonuc_o, 32'd14);

        // ---- flush together with request: no accept ----
        @(negedge clk_i);
        islem_i = 3'd5; deger1_i = 32'd9; deger2_i = 32'd0;
        istek_gecerli_i = 1'b1; iptal_i = 1'b1;
        @(posedge clk_i); #1;
        istek_gecerli_i = 1'b0; iptal_i = 1'b0;
        chk("flush+req hazir", {31'b0, hazir_o}, 32'd1);
        chk("flush+req gecerli", {31'b0, sonuc_gecerli_o}, 32'd0);

        // ---- async reset mid-HESAPLA ----
        @(negedge clk_i);
        islem_i = 3'd5; deger1_i = 32'h0000FFFF; deger2_i = 32'd3; istek_gecerli_i = 1'b1;
        @(posedge clk_i); #1; istek_gecerli_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("arst hazir", {31'b0, hazir_o}, 32'd1);
        chk("arst gecerli", {31'b0, sonuc_gecerli_o}, 32'd0);
        chk("arst sonuc", sonuc_o, 32'h0);
        @(negedge clk_i); rst_i = 1'b1;
        do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
